// File: rtl/floo_offload_reduction_unit.sv
// Offload reduction responder for a floo router.
// A lane-wise integer ALU feeds an elastic pipeline of NumStages register stages.
// Requests are taken in order and each produces exactly one response. Accept rate
// is one request per cycle.
//
// Handshake semantics (both req and resp channels):
//   - A transfer happens at a rising edge where valid and ready are both high.
//   - Once valid is high, it stays high with a stable payload until the transfer.
//   - ready never depends on valid of the same channel. req_ready_o is a function
//     of pipeline occupancy and resp_ready_i only.
module floo_offload_reduction_unit #(
  parameter int unsigned DataWidth = 64,
  parameter int unsigned ElemWidth = 32,
  parameter int unsigned NumStages = 2,
  parameter int unsigned OpWidth   = 3
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic [OpWidth-1:0]               req_op_i,
  input  logic [DataWidth-1:0]             req_operand1_i,
  input  logic [DataWidth-1:0]             req_operand2_i,
  input  logic                             req_valid_i,
  output logic                             req_ready_o,
  output logic [DataWidth-1:0]             resp_result_o,
  output logic                             resp_valid_o,
  input  logic                             resp_ready_i,
  output logic [$clog2(NumStages+1)-1:0]   inflight_o,
  output logic                             illegal_op_o
);

  localparam int unsigned NumLanes = DataWidth / ElemWidth;
  localparam int unsigned CntWidth = $clog2(NumStages + 1);

  localparam logic [OpWidth-1:0] OpAdd  = OpWidth'(0);
  localparam logic [OpWidth-1:0] OpMins = OpWidth'(1);
  localparam logic [OpWidth-1:0] OpMaxs = OpWidth'(2);
  localparam logic [OpWidth-1:0] OpMinu = OpWidth'(3);
  localparam logic [OpWidth-1:0] OpMaxu = OpWidth'(4);
  localparam logic [OpWidth-1:0] OpAnd  = OpWidth'(5);
  localparam logic [OpWidth-1:0] OpOr   = OpWidth'(6);
  localparam logic [OpWidth-1:0] OpXor  = OpWidth'(7);

  logic [DataWidth-1:0] alu_result;
  logic                 alu_illegal;
  logic [ElemWidth-1:0] lane_a;
  logic [ElemWidth-1:0] lane_b;
  logic [ElemWidth-1:0] lane_r;

  logic [NumStages-1:0] stage_valid;
  logic [DataWidth-1:0] stage_data [NumStages];
  logic [NumStages-1:0] stage_ready;
  logic                 full_from;

  logic                 accept;
  logic                 pop;
  logic [CntWidth-1:0]  inflight_q;
  logic                 illegal_q;

  // Lane-wise ALU; undefined op codes pass operand1 through unchanged.
  always_comb begin
    alu_result  = req_operand1_i;
    alu_illegal = 1'b0;
    lane_a      = '0;
    lane_b      = '0;
    lane_r      = '0;
    if (req_op_i > OpXor) begin
      alu_illegal = 1'b1;
    end else begin
      for (int k = 0; k < NumLanes; k++) begin
        lane_a = req_operand1_i[k*ElemWidth +: ElemWidth];
        lane_b = req_operand2_i[k*ElemWidth +: ElemWidth];
        case (req_op_i)
          OpAdd:   lane_r = lane_a + lane_b;
          OpMins:  lane_r = ($signed(lane_a) < $signed(lane_b)) ? lane_a : lane_b;
          OpMaxs:  lane_r = ($signed(lane_a) > $signed(lane_b)) ? lane_a : lane_b;
          OpMinu:  lane_r = (lane_a < lane_b) ? lane_a : lane_b;
          OpMaxu:  lane_r = (lane_a > lane_b) ? lane_a : lane_b;
          OpAnd:   lane_r = lane_a & lane_b;
          OpOr:    lane_r = lane_a | lane_b;
          OpXor:   lane_r = lane_a ^ lane_b;
          default: lane_r = lane_a;
        endcase
        alu_result[k*ElemWidth +: ElemWidth] = lane_r;
      end
    end
  end

  // Stage i may load when no stage from i to the end holds a stalled beat, so bubbles collapse.
  always_comb begin
    full_from   = 1'b1;
    stage_ready = '0;
    for (int i = NumStages - 1; i >= 0; i--) begin
      full_from      = full_from & stage_valid[i];
      stage_ready[i] = !full_from | resp_ready_i;
    end
  end

  assign accept = req_valid_i & stage_ready[0];
  assign pop    = stage_valid[NumStages-1] & resp_ready_i;

  // Stage 0 captures the ALU result. Later stages shift forward when they may load.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stage_valid <= '0;
      for (int i = 0; i < NumStages; i++) begin
        stage_data[i] <= '0;
      end
    end else begin
      if (stage_ready[0]) begin
        stage_valid[0] <= req_valid_i;
        if (req_valid_i) begin
          stage_data[0] <= alu_result;
        end
      end
      for (int i = 1; i < NumStages; i++) begin
        if (stage_ready[i]) begin
          stage_valid[i] <= stage_valid[i-1];
          if (stage_valid[i-1]) begin
            stage_data[i] <= stage_data[i-1];
          end
        end
      end
    end
  end

  // Occupancy counter: +1 on accept, -1 on response handshake.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      inflight_q <= '0;
    end else begin
      case ({accept, pop})
        2'b10:   inflight_q <= inflight_q + CntWidth'(1);
        2'b01:   inflight_q <= inflight_q - CntWidth'(1);
        default: inflight_q <= inflight_q;
      endcase
    end
  end

  // One-cycle flag following the accept of an undefined op.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      illegal_q <= 1'b0;
    end else begin
      illegal_q <= accept & alu_illegal;
    end
  end

  assign req_ready_o   = stage_ready[0];
  assign resp_valid_o  = stage_valid[NumStages-1];
  assign resp_result_o = stage_data[NumStages-1];
  assign inflight_o    = inflight_q;
  assign illegal_op_o  = illegal_q;

endmodule
